score_display: RTL and testbench



---
 rtl/score_display.sv | 143 ++++++++++++++
 tb/tb_score_display.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/score_display.sv
// Four-digit multiplexed 7-segment driver for the two player scores.
// Scores are latched once per scan frame; on game over the loser's digits blink.
module score_display #(
  parameter int unsigned REFRESH_DIV = 100000,
  parameter int unsigned BLINK_DIV   = 25000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] score_left,
  input  logic [3:0] score_right,
  input  logic       game_over,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       frame_start
);

  localparam int unsigned RW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam int unsigned BW = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  logic [RW-1:0] rcnt_q, rcnt_d;
  logic [1:0]    idx_q, idx_d;
  logic [BW-1:0] bcnt_q, bcnt_d;
  logic          blink_on_q, blink_on_d;
  logic [3:0]    snap_l_q, snap_l_d;
  logic [3:0]    snap_r_q, snap_r_d;
  logic          snap_go_q, snap_go_d;
  logic          first_q, first_d;
  logic [3:0]    an_q, an_d;
  logic [6:0]    seg_q, seg_d;
  logic          fs_q, fs_d;

  logic          rterm_c;
  logic          wrap_c;
  logic [3:0]    sel_val_c;
  logic          tens_c;
  logic [3:0]    units_c;
  logic          loser_c;
  logic [6:0]    digit_seg_c;

  function automatic logic [6:0] seg_code(input logic [3:0] d);
    case (d)
      4'd0:    seg_code = 7'b1000000;
      4'd1:    seg_code = 7'b1111001;
      4'd2:    seg_code = 7'b0100100;
      4'd3:    seg_code = 7'b0110000;
      4'd4:    seg_code = 7'b0011001;
      4'd5:    seg_code = 7'b0010010;
      4'd6:    seg_code = 7'b0000010;
      4'd7:    seg_code = 7'b1111000;
      4'd8:    seg_code = 7'b0000000;
      4'd9:    seg_code = 7'b0010000;
      default: seg_code = SEG_BLANK;
    endcase
  endfunction

  always_comb begin
    rcnt_d     = rcnt_q + RW'(1);
    idx_d      = idx_q;
    bcnt_d     = bcnt_q;
    blink_on_d = blink_on_q;
    snap_l_d   = snap_l_q;
    snap_r_d   = snap_r_q;
    snap_go_d  = snap_go_q;
    first_d    = 1'b0;

    // Scan position: dwell REFRESH_DIV cycles per digit.
    rterm_c = (rcnt_q == RW'(REFRESH_DIV - 1));
    if (rterm_c) begin
      rcnt_d = '0;
      idx_d  = idx_q + 2'd1;
    end
    wrap_c = rterm_c && (idx_q == 2'd3);

    // The first edge out of reset also loads so the display is valid immediately.
    if (wrap_c || first_q) begin
      snap_l_d  = score_left;
      snap_r_d  = score_right;
      snap_go_d = game_over;
    end

    // Blink phase follows the live game_over level, restarting lit on each rise.
    if (!game_over) begin
      bcnt_d     = '0;
      blink_on_d = 1'b1;
    end else if (bcnt_q == BW'(BLINK_DIV - 1)) begin
      bcnt_d     = '0;
      blink_on_d = ~blink_on_q;
    end else begin
      bcnt_d = bcnt_q + BW'(1);
    end

    sel_val_c = idx_q[1] ? snap_r_q : snap_l_q;
    tens_c    = (sel_val_c >= 4'd10);
    units_c   = tens_c ? (sel_val_c - 4'd10) : sel_val_c;

    if (idx_q[0]) begin
      digit_seg_c = seg_code(units_c);
    end else begin
      digit_seg_c = tens_c ? seg_code(4'd1) : SEG_BLANK;
    end

    // A tie makes both sides losers, so both blink.
    loser_c = idx_q[1] ? (snap_r_q <= snap_l_q) : (snap_l_q <= snap_r_q);

    an_d  = ~(4'b1000 >> idx_q);
    seg_d = (snap_go_q && !blink_on_q && loser_c) ? SEG_BLANK : digit_seg_c;
    fs_d  = wrap_c;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rcnt_q     <= '0;
      idx_q      <= 2'd0;
      bcnt_q     <= '0;
      blink_on_q <= 1'b1;
      snap_l_q   <= 4'd0;
      snap_r_q   <= 4'd0;
      snap_go_q  <= 1'b0;
      first_q    <= 1'b1;
      an_q       <= 4'b1111;
      seg_q      <= SEG_BLANK;
      fs_q       <= 1'b0;
    end else begin
      rcnt_q     <= rcnt_d;
      idx_q      <= idx_d;
      bcnt_q     <= bcnt_d;
      blink_on_q <= blink_on_d;
      snap_l_q   <= snap_l_d;
      snap_r_q   <= snap_r_d;
      snap_go_q  <= snap_go_d;
      first_q    <= first_d;
      an_q       <= an_d;
      seg_q      <= seg_d;
      fs_q       <= fs_d;
    end
  end

  assign an          = an_q;
  assign seg         = seg_q;
  assign frame_start = fs_q;

endmodule

// File: tb/tb_score_display.sv
// Randomized bench for score_display against a cycle-count based reference model.
module tb_score_display;

  localparam int unsigned R = 4;
  localparam int unsigned B = 8;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] score_left;
  logic [3:0] score_right;
  logic       game_over;
  logic [3:0] an;
  logic [6:0] seg;
  logic       frame_start;

  int unsigned n_chk  = 0;
  int unsigned n_fail = 0;

  // Reference model state: edges since reset release, latched scores, game-over run length.
  int unsigned m_edges;
  int unsigned m_go_run;
  int unsigned m_l;
  int unsigned m_r;
  bit          m_go;

  logic [6:0] codes [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                             7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};

  score_display #(.REFRESH_DIV(R), .BLINK_DIV(B)) dut (
    .clk         (clk),
    .reset       (reset),
    .score_left  (score_left),
    .score_right (score_right),
    .game_over   (game_over),
    .an          (an),
    .seg         (seg),
    .frame_start (frame_start)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t, edge %0d)", tag, got, exp, $time, m_edges);
    end
  endtask

  function automatic logic [6:0] digit_seg(input int unsigned v, input bit tens_pos);
    int unsigned t;
    int unsigned u;
    t = v / 10;
    u = v % 10;
    if (tens_pos) return (t == 0) ? 7'h7f : codes[t];
    return codes[u];
  endfunction

  task automatic step();
    int unsigned idx;
    bit          wrap;
    bit          lit_phase;
    int unsigned val;
    bit          loser;
    logic [3:0]  exp_an;
    logic [6:0]  exp_seg;
    idx       = (m_edges / R) % 4;
    wrap      = (m_edges % (4 * R)) == (4 * R - 1);
    lit_phase = ((m_go_run / B) % 2) == 0;
    val       = (idx < 2) ? m_l : m_r;
    loser     = (idx < 2) ? (m_l <= m_r) : (m_r <= m_l);
    exp_an    = 4'hf;
    exp_an[3 - idx] = 1'b0;
    exp_seg   = (m_go && !lit_phase && loser) ? 7'h7f : digit_seg(val, (idx % 2) == 0);
    @(posedge clk);
    #1;
    chk("an", 32'(an), 32'(exp_an));
    chk("seg", 32'(seg), 32'(exp_seg));
    chk("frame_start", 32'(frame_start), 32'(wrap));
    if (m_edges == 0 || wrap) begin
      m_l  = score_left;
      m_r  = score_right;
      m_go = game_over;
    end
    m_go_run = game_over ? m_go_run + 1 : 0;
    m_edges++;
  endtask

  task automatic run(input int unsigned n);
    repeat (n) step();
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    #1;
    chk("rst_an", 32'(an), 32'hf);
    chk("rst_seg", 32'(seg), 32'h7f);
    chk("rst_fs", 32'(frame_start), 32'h0);
    m_edges  = 0;
    m_go_run = 0;
    m_l      = 0;
    m_r      = 0;
    m_go     = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_hold_an", 32'(an), 32'hf);
    chk("rst_hold_seg", 32'(seg), 32'h7f);
    reset = 1'b0;
  endtask

  task automatic to_frame_start();
    while ((m_edges % (4 * R)) != 0) step();
  endtask

  initial begin
    score_left  = 4'd0;
    score_right = 4'd0;
    game_over   = 1'b0;
    apply_reset();

    // Idle scores 0/0, then 3/10.
    run(20);
    score_left  = 4'd3;
    score_right = 4'd10;
    run(40);

    // Mid-frame change must wait for the next snapshot.
    score_right = 4'd4;
    to_frame_start();
    run(4 * R + 2);
    score_right = 4'd5;
    run(4 * R * 2);

    // Right side loses and blinks.
    score_left  = 4'd10;
    score_right = 4'd7;
    game_over   = 1'b1;
    run(80);

    // Tie: all digits blink; then release game over.
    score_right = 4'd10;
    run(70);
    game_over = 1'b0;
    run(40);

    // Mid-frame reset while scanning idx2.
    game_over  = 1'b1;
    score_left = 4'd2;
    run(5);
    while (((m_edges / R) % 4) != 2) step();
    step();
    apply_reset();
    run(20);

    // Randomized phases, including scores above ten.
    for (int p = 0; p < 30; p++) begin
      score_left  = 4'($urandom_range(0, 15));
      score_right = 4'($urandom_range(0, 15));
      game_over   = 1'($urandom_range(0, 1));
      run($urandom_range(3, 60));
      if (($urandom_range(0, 9)) == 0) begin
        #($urandom_range(1, 7));
        apply_reset();
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
